// File: rtl/ins_mem_loader_if.sv
// ins_mem_loader_if: byte stream, instruction memory write port and load status of ins_mem_loader
interface ins_mem_loader_if;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;
  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data, busy, done, err
  );
  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/ins_mem_loader.sv
// ins_mem_loader: boot loader; count header, big-endian words to imem from address 0, XOR checksum; clk/rst plain, stream/write/status on bus (slave)
module ins_mem_loader #(
  parameter int DEPTH = 4096
) (
  input logic             clk,
  input logic             rst,
  ins_mem_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, BYTE, WRITE, CKSUM, DONE, ERROR} state_t;
  state_t      state, nxt;
  logic [15:0] cnt, idx, n;
  logic [23:0] word;
  logic [7:0]  cks;
  logic [1:0]  bcnt;
  logic        xfer, arm;
  assign xfer = bus.byte_valid && bus.byte_ready;
  assign n    = {cnt[15:8], bus.byte_in};
  assign arm  = bus.start && (state == IDLE || state == DONE || state == ERROR);
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERROR: nxt = bus.start ? HDR_HI : state;
      HDR_HI:            nxt = xfer ? HDR_LO : state;
      HDR_LO:            nxt = !xfer ? state : n > 16'(DEPTH) ? ERROR : n == 16'd0 ? CKSUM : BYTE;
      BYTE:              nxt = xfer && bcnt == 2'd3 ? WRITE : state;
      WRITE:             nxt = idx + 16'd1 == cnt ? CKSUM : BYTE;
      CKSUM:             nxt = !xfer ? state : bus.byte_in == cks ? DONE : ERROR;
      default:           nxt = IDLE;
    endcase
  end
  // Outputs are registered from the next state, so they track state with no path from byte_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      idx            <= '0;
      word           <= '0;
      cks            <= '0;
      bcnt           <= '0;
      bus.byte_ready <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
    end else begin
      state          <= nxt;
      bus.byte_ready <= nxt inside {HDR_HI, HDR_LO, BYTE, CKSUM};
      bus.busy       <= nxt inside {HDR_HI, HDR_LO, BYTE, WRITE, CKSUM};
      bus.done       <= nxt == DONE;
      bus.err        <= nxt == ERROR;
      bus.wr_en      <= nxt == WRITE;
      if (arm) begin
        idx  <= '0;
        cks  <= '0;
        bcnt <= '0;
      end
      if (state == HDR_HI && xfer) cnt[15:8] <= bus.byte_in;
      if (state == HDR_LO && xfer) cnt[7:0] <= bus.byte_in;
      if (state == BYTE && xfer) begin
        word <= {word[15:0], bus.byte_in};
        cks  <= cks ^ bus.byte_in;
        bcnt <= bcnt + 2'd1;
      end
      // The 4th byte goes straight into wr_data; word holds only the first three.
      if (nxt == WRITE) begin
        bus.wr_data <= {word, bus.byte_in};
        bus.wr_addr <= {16'd0, idx};
      end
      if (state == WRITE) idx <= idx + 16'd1;
    end
  end
endmodule

// File: tb/tb_ins_mem_loader.sv
// tb_ins_mem_loader: directed self-checking bench for ins_mem_loader
module tb_ins_mem_loader;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  int bad = 0;
  logic prev_we = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [7:0] s1[$];
  logic [7:0] s2[$];
  logic [31:0] ea[2] = '{32'd0, 32'd1};
  logic [31:0] ed[2] = '{32'h8C010384, 32'h8C020385};
  ins_mem_loader_if bus();
  ins_mem_loader #(.DEPTH(4096)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.wr_en) begin
      wa.push_back(bus.wr_addr);
      wd.push_back(bus.wr_data);
      if (bus.byte_ready || prev_we) bad++;
    end
    prev_we = bus.wr_en;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic pulse_start;
    bus.start = 1;
    @(posedge clk);
    #1 bus.start = 0;
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap, input bit inj);
    logic r;
    for (int i = 0; i < gap; i++) begin
      bus.byte_valid = 0;
      bus.start = inj && i == 0;
      @(posedge clk);
      #1 bus.start = 0;
    end
    bus.byte_in = b;
    bus.byte_valid = 1;
    for (int t = 0; ; t++) begin
      r = bus.byte_ready;
      @(posedge clk);
      #1;
      if (r) break;
      if (t > 200) begin
        checks++;
        errors++;
        $display("FAIL timeout waiting for byte_ready");
        break;
      end
    end
    bus.byte_valid = 0;
  endtask
  task automatic send_stream(input logic [7:0] s[$], input bit gaps);
    int g;
    bit inj;
    pulse_start();
    for (int i = 0; i < s.size(); i++) begin
      g = gaps ? int'($urandom_range(0, 3)) : 0;
      inj = gaps && (i == 5 || $urandom_range(0, 3) == 0);
      if (i == 5) g = g + 1;
      send_byte(s[i], g, inj);
    end
  endtask
  task automatic check_img(input string tag);
    chk({tag, "_wr_cnt"}, 32'(wa.size()), 32'd2);
    for (int i = 0; i < wa.size() && i < 2; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wa[i], ea[i]);
      chk($sformatf("%s_data%0d", tag, i), wd[i], ed[i]);
    end
  endtask
  task automatic clear_log;
    wa.delete();
    wd.delete();
  endtask
  initial begin
    bus.start = 0;
    bus.byte_in = 0;
    bus.byte_valid = 0;
    s1 = '{8'h00, 8'h02, 8'h8C, 8'h01, 8'h03, 8'h84, 8'h8C, 8'h02, 8'h03, 8'h85, 8'h02};
    s2 = s1;
    s2[10] = 8'h03;
    #1;
    chk("rst_flags", {27'd0, bus.busy, bus.done, bus.err, bus.byte_ready, bus.wr_en}, 32'd0);
    chk("rst_addr", bus.wr_addr, 32'd0);
    chk("rst_data", bus.wr_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk);
    #1;
    send_stream(s1, 0);
    chk("t1_done", bus.done, 1);
    chk("t1_err", bus.err, 0);
    chk("t1_busy", bus.busy, 0);
    check_img("t1");
    clear_log();
    send_stream(s2, 0);
    chk("t2_err", bus.err, 1);
    chk("t2_done", bus.done, 0);
    check_img("t2");
    clear_log();
    pulse_start();
    chk("t2_err_clr", bus.err, 0);
    chk("t2_busy_rearm", bus.busy, 1);
    for (int i = 0; i < s1.size(); i++) send_byte(s1[i], 0, 0);
    chk("t2_redone", bus.done, 1);
    check_img("t2b");
    clear_log();
    pulse_start();
    send_byte(8'h10, 0, 0);
    send_byte(8'h01, 0, 0);
    chk("t3_err", bus.err, 1);
    chk("t3_ready", bus.byte_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_ready_later", bus.byte_ready, 0);
    chk("t3_wr_cnt", 32'(wa.size()), 0);
    pulse_start();
    send_byte(8'h00, 0, 0);
    send_byte(8'h00, 0, 0);
    send_byte(8'h00, 0, 0);
    chk("t4_done", bus.done, 1);
    chk("t4_err", bus.err, 0);
    pulse_start();
    send_byte(8'h00, 0, 0);
    send_byte(8'h00, 0, 0);
    send_byte(8'h5A, 0, 0);
    chk("t4_bad_err", bus.err, 1);
    chk("t4_wr_cnt", 32'(wa.size()), 0);
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(s1[i], 0, 0);
    rst = 1;
    #1;
    chk("t5_flags", {27'd0, bus.busy, bus.done, bus.err, bus.byte_ready, bus.wr_en}, 32'd0);
    chk("t5_addr", bus.wr_addr, 32'd0);
    chk("t5_data", bus.wr_data, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("t5_wr_cnt", 32'(wa.size()), 1);
    clear_log();
    send_stream(s1, 0);
    chk("t5_done", bus.done, 1);
    check_img("t5");
    clear_log();
    send_stream(s1, 1);
    chk("t6_done", bus.done, 1);
    chk("t6_err", bus.err, 0);
    check_img("t6");
    repeat (3) @(posedge clk);
    #1;
    chk("wr_pulse_overlap", 32'(bad), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ins_mem_loader.md
# ins_mem_loader

Boot-time program loader: the write side of the instruction memory. Receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them to consecutive word addresses starting at 0. It holds the processor in reset until a verified image is in place. It sits between the host byte link (UART receiver or testbench) and the instruction memory write port.

## Interface
- DEPTH, 4096: instruction memory depth in words; maximum accepted word count.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that arms a load; sampled only in IDLE, DONE or ERROR.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  loader accepts byte_in this cycle; a transfer occurs when byte_valid && byte_ready.
- wr_en  out  1  one-cycle instruction memory write strobe.
- wr_addr  out  32  word address of the write; bits above log2(DEPTH)-1 are always 0.
- wr_data  out  32  instruction word.
- busy  out  1  load in progress; the processor is held while busy is high.
- done  out  1  level; image loaded and checksum matched.
- err  out  1  level; bad count or checksum mismatch.

## Operation
- Stream format: count_hi, count_lo (16-bit word count N, big-endian), then 4N payload bytes (each word MSB first), then 1 checksum byte equal to the XOR of all 4N payload bytes. The header is not included in the checksum.
- States:
  - IDLE: on start, go to HDR_HI.
  - HDR_HI: on transfer, latch count_hi and go to HDR_LO.
  - HDR_LO: on transfer, latch count_lo.
    - N > DEPTH: go to ERROR.
    - N == 0: go to CKSUM.
    - Otherwise: go to BYTE.
  - BYTE: shift each accepted byte into a 32-bit assembly register and XOR it into the running checksum. After the 4th byte of the word, go to WRITE.
  - WRITE: wr_en=1 with the assembled word and the current word index. Increment the index. Return to BYTE, or go to CKSUM if this was word N-1.
  - CKSUM: on transfer, compare the byte with the running XOR. Match goes to DONE; mismatch goes to ERROR.
  - DONE and ERROR: on start, go to HDR_HI. Index, checksum and byte counter clear to 0, and done/err clear.
- byte_ready is 1 only in HDR_HI, HDR_LO, BYTE and CKSUM.
- busy is 1 in HDR_HI through CKSUM.
- done is 1 only in DONE; err is 1 only in ERROR.
- A start pulse while busy is ignored.
- Words written before a checksum mismatch stay in memory. err keeps the processor held, and the external controller must not release it.
- Word index arithmetic is 16-bit unsigned. wr_addr is the index zero-extended to 32 bits.

## Timing
- Reset: state IDLE, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0. Internal counters and the checksum clear to 0. All of these take effect immediately on rst assertion, with no clock edge required.
- Reset mid-load abandons the image. No wr_en is issued after rst asserts. The next start restarts at address 0.
- All outputs are registered and depend only on state, with no combinational path from byte_valid.
- If the 4th byte of a word transfers at edge k, wr_en is high for exactly the cycle following edge k, and byte_ready is 0 during that cycle.
- Peak throughput is 4 bytes per 5 cycles.
- byte_valid gaps of any length stall the FSM without any side effects.
- N=DEPTH is legal: the last write goes to address DEPTH-1.
- done/err rise one cycle after the final CKSUM transfer, or after the HDR_LO transfer for an oversize count.

## Test plan
- Stream 00 02 8C 01 03 84 8C 02 03 85 02 with byte_valid held high -> two writes: addr 0 = 0x8C010384, addr 1 = 0x8C020385. Each wr_en lasts 1 cycle, done=1, err=0, busy falls with done.
- Same stream with checksum 0x03 -> both writes still occur, then err=1, done=0. A following start clears err and a valid stream then reaches done.
- Header 10 01 (N=4097) -> err=1 one cycle after the second header byte, no wr_en, byte_ready=0 thereafter.
- Header 00 00 followed by checksum 00 -> done=1 with no wr_en. With checksum 5A instead -> err=1.
- rst asserted after 5 payload bytes of a 2-word load -> all outputs 0 immediately, no further writes. Then start plus the full first stream -> writes begin at addr 0 and done=1.
- First stream with random byte_valid gaps and start pulses injected mid-load -> the write sequence and done are identical to the gap-free case, and the extra starts are ignored.
